// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared helpers for the convolution window datapath: window
//               element indexing, history tap offsets and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Bit width of a counter that spans 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flat index of window element (r, c); r=0 is the top row, c=0 the left column.
    function automatic int idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Number of accepts between window element (r, c) and the newest pixel.
    // The newest pixel sits at the bottom-right corner (offset 0).
    function automatic int tap_offset(input int r, input int c, input int k,
                                      input int row_size);
        return (k - 1 - r) * row_size + (k - 1 - c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_tap_chain.sv
`default_nettype none
// ============================================================================
// Module      : shift_tap_chain
// Description : Enable-gated pixel history shift register with synchronous
//               clear. Exposes DEPTH taps; tap 0 is the incoming pixel itself,
//               tap k is the pixel accepted k enables earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_tap_chain #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic [DEPTH*DATA_WIDTH-1:0]   o_taps
);

    // Only DEPTH-1 pixels need storage: the newest tap is the live input.
    localparam int c_HIST_BITS = (DEPTH - 1) * DATA_WIDTH;

    logic [c_HIST_BITS-1:0] r_hist;

    // Shift the accepted pixel in at the low end; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (i_en) begin
            r_hist <= {r_hist[c_HIST_BITS-DATA_WIDTH-1:0], i_data};
        end
    end

    assign o_taps = {r_hist, i_data};

endmodule
`default_nettype wire

// File: rtl/conv_window_generator.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_generator
// Description : Converts a raster-order pixel stream into KxK convolution
//               windows. Tracks row/column position with stride phase
//               counters, flags in-image windows and pulses frame_done with
//               the last accept of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_generator
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_SIZE    = 5,
    parameter int COL_SIZE    = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                        clock,
    input  logic                                        sreset,
    input  logic                                        data_valid,
    input  logic [DATA_WIDTH-1:0]                       data_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
    output logic                                        window_valid,
    output logic                                        frame_done
);

    localparam int c_DEPTH  = (KERNEL_SIZE - 1) * ROW_SIZE + KERNEL_SIZE;
    localparam int c_WIN_W  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
    localparam int c_COL_W  = cnt_width(ROW_SIZE);
    localparam int c_ROW_W  = cnt_width(COL_SIZE);
    localparam int c_PH_W   = cnt_width(STRIDE);

    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(ROW_SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(COL_SIZE - 1);
    localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(KERNEL_SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(KERNEL_SIZE - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST   = c_PH_W'(STRIDE - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE    = c_PH_W'(1);

    logic [c_COL_W-1:0]       r_col;
    logic [c_ROW_W-1:0]       r_row;
    logic [c_PH_W-1:0]        r_col_ph;
    logic [c_PH_W-1:0]        r_row_ph;
    logic [c_WIN_W-1:0]       r_window;
    logic                     r_window_valid;
    logic                     r_frame_done;

    logic [c_DEPTH*DATA_WIDTH-1:0] w_taps;
    logic [c_WIN_W-1:0]            w_window_next;
    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_col_in;
    logic                          w_row_in;
    logic                          w_qualify;
    logic                          w_unused_taps;

    shift_tap_chain #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_DEPTH)
    ) u_chain (
        .clk    (clock),
        .rst    (sreset),
        .i_en   (data_valid),
        .i_data (data_in),
        .o_taps (w_taps)
    );

    // Route the KxK window positions out of the history chain.
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
            assign w_window_next[idx(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                w_taps[tap_offset(r, c, KERNEL_SIZE, ROW_SIZE)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Taps between the window rows are history only, never part of a window.
    assign w_unused_taps = ^w_taps;

    // Position decode for the pixel being accepted this cycle.
    always_comb begin
        w_col_last = (r_col == c_COL_LAST);
        w_row_last = (r_row == c_ROW_LAST);
        w_col_in   = (r_col >= c_COL_FIRST);
        w_row_in   = (r_row >= c_ROW_FIRST);
        // Columns below K-1 would pull pixels from the previous row, so a
        // window straddling the row wrap is never flagged.
        w_qualify  = w_col_in && w_row_in && (r_col_ph == '0) && (r_row_ph == '0);
    end

    // Raster position and stride phase counters; phases start counting once
    // their coordinate reaches the first full-window position.
    always_ff @(posedge clock) begin
        if (sreset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (data_valid) begin
            if (w_col_last) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (w_row_last) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row <= r_row + c_ROW_W'(1);
                    if (w_row_in) begin
                        r_row_ph <= (r_row_ph == c_PH_LAST) ? '0 : r_row_ph + c_PH_ONE;
                    end
                end
            end else begin
                r_col <= r_col + c_COL_W'(1);
                if (w_col_in) begin
                    r_col_ph <= (r_col_ph == c_PH_LAST) ? '0 : r_col_ph + c_PH_ONE;
                end
            end
        end
    end

    // Output registers: the window updates on every accept, the flags pulse
    // only on the cycle after a qualifying or frame-ending accept.
    always_ff @(posedge clock) begin
        if (sreset) begin
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= data_valid && w_qualify;
            r_frame_done   <= data_valid && w_col_last && w_row_last;
            if (data_valid) begin
                r_window <= w_window_next;
            end
        end
    end

    assign window_out   = r_window;
    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
